cb_boot_sequencer: RTL and testbench

Safe-CPU boot/run sequencer sitting directly downstream of the safe-CPU control register block. It consumes the start, boot-address, master-core, safe-mode and safe-configuration fields, and releases the selected cores from reset with a common boot address. It tracks each core's completion and returns the end-of-software-routine level that the control block uses to clear its start bit.

---
 rtl/cb_boot_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_cb_boot_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cb_boot_sequencer.sv
// Safe-CPU boot/run sequencer: holds cores in reset, releases the selected set with a
// common boot address and reports end of routine. Optional RUN watchdog: CB_BOOT_TIMEOUT_EN.
module cb_boot_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES = 4,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd1048576
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] boot_addr_i,
  input  logic [2:0]  master_core_i,
  input  logic        safe_mode_i,
  input  logic [1:0]  safe_configuration_i,
  input  logic [2:0]  core_done_i,
  output logic [2:0]  core_rst_no,
  output logic [2:0]  core_fetch_en_o,
  output logic [31:0] core_boot_addr_o,
  output logic [2:0]  active_mask_o,
  output logic        busy_o,
  output logic        end_sw_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_BOOT  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [7:0] HOLD_LOAD = 8'(RST_HOLD_CYCLES - 32'd1);

  if ((RST_HOLD_CYCLES < 32'd1) || (RST_HOLD_CYCLES > 32'd255)) begin : g_bad_hold
    $error("cb_boot_sequencer: RST_HOLD_CYCLES out of range 1..255");
  end
  if (TIMEOUT_CYCLES == 32'd0) begin : g_bad_timeout
    $error("cb_boot_sequencer: TIMEOUT_CYCLES must be at least 1");
  end

  // Single-core mode picks the lowest requested core (core 0 if none); redundant
  // mode maps the configuration onto a fixed core set, never an empty one.
  function automatic logic [2:0] decode_mask(input logic       safe_mode,
                                             input logic [1:0] cfg,
                                             input logic [2:0] master);
    logic [2:0] mask;
    if (safe_mode == 1'b0) begin
      if (master[0])      mask = 3'b001;
      else if (master[1]) mask = 3'b010;
      else if (master[2]) mask = 3'b100;
      else                mask = 3'b001;
    end else begin
      case (cfg)
        2'b00:   mask = 3'b111;
        2'b01:   mask = 3'b011;
        2'b10:   mask = 3'b110;
        2'b11:   mask = 3'b111;
        default: mask = 3'b111;
      endcase
    end
    return mask;
  endfunction

  state_e      state_r;
  state_e      next_state_s;
  logic [7:0]  hold_cnt_r;
  logic [31:0] boot_addr_r;
  logic [2:0]  mask_r;
  logic [2:0]  done_r;
  logic        start_latch_s;
  logic        complete_s;
  logic        timeout_hit_s;

  assign start_latch_s = (state_r == ST_IDLE) && start_i;
  assign complete_s    = (((done_r | core_done_i) & mask_r) == mask_r);

`ifdef CB_BOOT_TIMEOUT_EN
  logic [31:0] run_cnt_r;
  logic        timeout_r;

  assign timeout_hit_s = (run_cnt_r == (TIMEOUT_CYCLES - 32'd1));

  // Watchdog counter (restarts on entry to RUN) and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_cnt_r <= 32'd0;
      timeout_r <= 1'b0;
    end else begin
      if (state_r == ST_BOOT) begin
        run_cnt_r <= 32'd0;
      end else if (state_r == ST_RUN) begin
        run_cnt_r <= run_cnt_r + 32'd1;
      end
      if (start_latch_s) begin
        timeout_r <= 1'b0;
      end else if ((state_r == ST_RUN) && start_i && !complete_s && timeout_hit_s) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_r;
`else
  assign timeout_hit_s = 1'b0;
  assign timeout_o     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a falling start_i aborts any active phase and beats completion.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) next_state_s = ST_RESET;
        else         next_state_s = ST_IDLE;
      end
      ST_RESET: begin
        if (!start_i)                next_state_s = ST_IDLE;
        else if (hold_cnt_r == 8'd0) next_state_s = ST_BOOT;
        else                         next_state_s = ST_RESET;
      end
      ST_BOOT: begin
        if (!start_i) next_state_s = ST_IDLE;
        else          next_state_s = ST_RUN;
      end
      ST_RUN: begin
        if (!start_i)          next_state_s = ST_IDLE;
        else if (complete_s)   next_state_s = ST_DONE;
        else if (timeout_hit_s) next_state_s = ST_DONE;
        else                   next_state_s = ST_RUN;
      end
      ST_DONE: begin
        if (!start_i) next_state_s = ST_IDLE;
        else          next_state_s = ST_DONE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Start-time latches, reset hold counter and sticky per-core completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_cnt_r  <= 8'd0;
      boot_addr_r <= 32'd0;
      mask_r      <= 3'b000;
      done_r      <= 3'b000;
    end else begin
      if (start_latch_s) begin
        hold_cnt_r  <= HOLD_LOAD;
        boot_addr_r <= boot_addr_i;
        mask_r      <= decode_mask(safe_mode_i, safe_configuration_i, master_core_i);
        done_r      <= 3'b000;
      end else if (state_r == ST_RESET) begin
        if (hold_cnt_r != 8'd0) hold_cnt_r <= hold_cnt_r - 8'd1;
      end else if (state_r == ST_RUN) begin
        done_r <= done_r | (core_done_i & mask_r);
      end
    end
  end

  // Outputs decoded purely from state and latched registers.
  always_comb begin
    core_rst_no     = 3'b000;
    core_fetch_en_o = 3'b000;
    busy_o          = 1'b0;
    end_sw_o        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_o = 1'b0;
      end
      ST_RESET: begin
        busy_o = 1'b1;
      end
      ST_BOOT: begin
        core_rst_no = mask_r;
        busy_o      = 1'b1;
      end
      ST_RUN: begin
        core_rst_no     = mask_r;
        core_fetch_en_o = mask_r;
        busy_o          = 1'b1;
      end
      ST_DONE: begin
        end_sw_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  assign core_boot_addr_o = boot_addr_r;
  assign active_mask_o    = mask_r;

endmodule

// File: tb/tb_cb_boot_sequencer.sv
// Directed self-checking bench for cb_boot_sequencer (RST_HOLD_CYCLES=4, TIMEOUT_CYCLES=16).
module tb_cb_boot_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [31:0] boot_addr_i;
  logic [2:0]  master_core_i;
  logic        safe_mode_i;
  logic [1:0]  safe_configuration_i;
  logic [2:0]  core_done_i;
  logic [2:0]  core_rst_no;
  logic [2:0]  core_fetch_en_o;
  logic [31:0] core_boot_addr_o;
  logic [2:0]  active_mask_o;
  logic        busy_o;
  logic        end_sw_o;
  logic        timeout_o;

  int errors = 0;
  int checks = 0;

  cb_boot_sequencer #(
    .RST_HOLD_CYCLES(4),
    .TIMEOUT_CYCLES (32'd16)
  ) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .start_i             (start_i),
    .boot_addr_i         (boot_addr_i),
    .master_core_i       (master_core_i),
    .safe_mode_i         (safe_mode_i),
    .safe_configuration_i(safe_configuration_i),
    .core_done_i         (core_done_i),
    .core_rst_no         (core_rst_no),
    .core_fetch_en_o     (core_fetch_en_o),
    .core_boot_addr_o    (core_boot_addr_o),
    .active_mask_o       (active_mask_o),
    .busy_o              (busy_o),
    .end_sw_o            (end_sw_o),
    .timeout_o           (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Raise start and advance to the first RUN cycle (4 RESET + 1 BOOT + 1).
  task automatic go_to_run(input logic [2:0] exp_mask);
    start_i = 1'b1;
    repeat (6) step();
    check_val("run_fetch", {29'd0, core_fetch_en_o}, {29'd0, exp_mask});
  endtask

  task automatic end_run();
    start_i = 1'b0;
    step();
    check_val("idle_busy", {31'd0, busy_o}, 32'd0);
  endtask

  // Start, read the latched mask in RESET, then abort.
  task automatic mask_probe(input logic sm, input logic [1:0] cfg, input logic [2:0] mst,
                            input logic [2:0] exp_mask);
    safe_mode_i          = sm;
    safe_configuration_i = cfg;
    master_core_i        = mst;
    start_i              = 1'b1;
    step();
    check_val("mask_decode", {29'd0, active_mask_o}, {29'd0, exp_mask});
    start_i = 1'b0;
    step();
    check_val("abort_reset", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    rst_ni               = 1'b0;
    start_i              = 1'b0;
    boot_addr_i          = 32'd0;
    master_core_i        = 3'b000;
    safe_mode_i          = 1'b0;
    safe_configuration_i = 2'b00;
    core_done_i          = 3'b000;
    repeat (3) step();
    check_val("rst_core_rst", {29'd0, core_rst_no}, 32'd0);
    check_val("rst_fetch", {29'd0, core_fetch_en_o}, 32'd0);
    check_val("rst_addr", core_boot_addr_o, 32'd0);
    check_val("rst_mask", {29'd0, active_mask_o}, 32'd0);
    check_val("rst_busy_end_to", {29'd0, busy_o, end_sw_o, timeout_o}, 32'd0);
    rst_ni = 1'b1;
    step();

    // Single-core run on core 1
    master_core_i = 3'b010;
    boot_addr_i   = 32'h0000_1000;
    start_i       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("sc_hold_rst", {29'd0, core_rst_no}, 32'd0);
      check_val("sc_hold_busy", {31'd0, busy_o}, 32'd1);
      boot_addr_i   = 32'hDEAD_BEEF;
      master_core_i = 3'b100;
    end
    step();
    check_val("sc_boot_rst", {29'd0, core_rst_no}, 32'h2);
    check_val("sc_boot_fetch", {29'd0, core_fetch_en_o}, 32'd0);
    step();
    check_val("sc_run_fetch", {29'd0, core_fetch_en_o}, 32'h2);
    check_val("sc_run_rst", {29'd0, core_rst_no}, 32'h2);
    check_val("sc_addr", core_boot_addr_o, 32'h0000_1000);
    check_val("sc_mask", {29'd0, active_mask_o}, 32'h2);
    step();
    check_val("sc_wait_end", {31'd0, end_sw_o}, 32'd0);
    core_done_i = 3'b010;
    step();
    core_done_i = 3'b000;
    check_val("sc_end_sw", {31'd0, end_sw_o}, 32'd1);
    check_val("sc_done_rst", {29'd0, core_rst_no}, 32'd0);
    check_val("sc_done_fetch", {29'd0, core_fetch_en_o}, 32'd0);
    check_val("sc_done_busy", {31'd0, busy_o}, 32'd0);
    step();
    check_val("sc_end_hold", {31'd0, end_sw_o}, 32'd1);
    start_i = 1'b0;
    step();
    check_val("sc_end_drop", {31'd0, end_sw_o}, 32'd0);
    check_val("sc_idle_busy", {31'd0, busy_o}, 32'd0);
    step();
    check_val("sc_idle_rst", {29'd0, core_rst_no}, 32'd0);

    // TMR run: completion only after the last of cores 0, 2, 1
    safe_mode_i          = 1'b1;
    safe_configuration_i = 2'b00;
    go_to_run(3'b111);
    check_val("tmr_mask", {29'd0, active_mask_o}, 32'h7);
    core_done_i = 3'b001; step(); core_done_i = 3'b000;
    check_val("tmr_after_c0", {31'd0, end_sw_o}, 32'd0);
    core_done_i = 3'b100; step(); core_done_i = 3'b000;
    check_val("tmr_after_c2", {31'd0, end_sw_o}, 32'd0);
    step();
    check_val("tmr_gap", {31'd0, end_sw_o}, 32'd0);
    core_done_i = 3'b010; step(); core_done_i = 3'b000;
    check_val("tmr_after_c1", {31'd0, end_sw_o}, 32'd1);
    end_run();

    // DMR 10 with stray core-0 done pulses
    safe_configuration_i = 2'b10;
    go_to_run(3'b110);
    check_val("dmr_rst", {29'd0, core_rst_no}, 32'h6);
    core_done_i = 3'b001; step(); core_done_i = 3'b000;
    check_val("dmr_stray0", {31'd0, end_sw_o}, 32'd0);
    core_done_i = 3'b011; step(); core_done_i = 3'b000;
    check_val("dmr_c1", {31'd0, end_sw_o}, 32'd0);
    core_done_i = 3'b001; step(); core_done_i = 3'b000;
    check_val("dmr_stray1", {31'd0, end_sw_o}, 32'd0);
    core_done_i = 3'b100; step(); core_done_i = 3'b000;
    check_val("dmr_c2", {31'd0, end_sw_o}, 32'd1);
    end_run();

    // Mask decode corner cases, each aborted from RESET
    mask_probe(1'b0, 2'b00, 3'b000, 3'b001);
    mask_probe(1'b0, 2'b00, 3'b110, 3'b010);
    mask_probe(1'b0, 2'b00, 3'b100, 3'b100);
    mask_probe(1'b1, 2'b01, 3'b000, 3'b011);
    mask_probe(1'b1, 2'b11, 3'b000, 3'b111);

    // Abort in the second RUN cycle, together with a completing done pulse
    safe_mode_i   = 1'b0;
    master_core_i = 3'b001;
    go_to_run(3'b001);
    step();
    start_i     = 1'b0;
    core_done_i = 3'b001;
    step();
    core_done_i = 3'b000;
    check_val("abort_end_sw", {31'd0, end_sw_o}, 32'd0);
    check_val("abort_rst", {29'd0, core_rst_no}, 32'd0);
    check_val("abort_fetch", {29'd0, core_fetch_en_o}, 32'd0);
    check_val("abort_busy", {31'd0, busy_o}, 32'd0);
    step();
    check_val("abort_end_sw2", {31'd0, end_sw_o}, 32'd0);

    // Watchdog: no completion for a long RUN
    go_to_run(3'b001);
`ifdef CB_BOOT_TIMEOUT_EN
    repeat (15) step();
    check_val("to_before", {30'd0, end_sw_o, timeout_o}, 32'd0);
    step();
    check_val("to_end_sw", {31'd0, end_sw_o}, 32'd1);
    check_val("to_flag", {31'd0, timeout_o}, 32'd1);
    start_i = 1'b0;
    step();
    check_val("to_sticky", {31'd0, timeout_o}, 32'd1);
    start_i = 1'b1;
    step();
    check_val("to_clear", {31'd0, timeout_o}, 32'd0);
    end_run();
`else
    repeat (40) step();
    check_val("noto_busy", {31'd0, busy_o}, 32'd1);
    check_val("noto_end_to", {30'd0, end_sw_o, timeout_o}, 32'd0);
    end_run();
`endif

    // Asynchronous reset in the middle of RUN
    boot_addr_i   = 32'h8000_0040;
    master_core_i = 3'b100;
    go_to_run(3'b100);
    check_val("ar_addr_pre", core_boot_addr_o, 32'h8000_0040);
    rst_ni = 1'b0;
    #1;
    check_val("ar_rst", {29'd0, core_rst_no}, 32'd0);
    check_val("ar_fetch", {29'd0, core_fetch_en_o}, 32'd0);
    check_val("ar_addr", core_boot_addr_o, 32'd0);
    check_val("ar_mask", {29'd0, active_mask_o}, 32'd0);
    check_val("ar_flags", {29'd0, busy_o, end_sw_o, timeout_o}, 32'd0);
    start_i = 1'b0;
    #3;
    rst_ni = 1'b1;
    step();
    check_val("ar_idle", {31'd0, busy_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
